// File: rtl/axi_stream_insert_header.sv
// axi_stream_insert_header
//
// Prepends a variable-length header (0..DATA_BYTE_WD bytes, taken from the
// low end of one header word) to each AXI-Stream packet. The output is a
// byte-packed stream, most-significant byte first: header bytes, then every
// payload byte, with the final beat's keep MSB-aligned.
//
// Ports
//   clk, rst_n        clock; synchronous reset, active HIGH (1 = reset)
//   valid_in/ready_in payload handshake; data_in, keep_in, last_in
//   valid_out/ready_out output handshake; data_out, keep_out, last_out
//   valid_insert/ready_insert header handshake; data_insert, keep_insert,
//                     byte_insert_cnt (header byte count k, authoritative)
module axi_stream_insert_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD:0]    byte_insert_cnt,
  output logic                    ready_insert
);

  localparam int N = DATA_BYTE_WD;

  typedef enum logic [1:0] {IDLE, DATA, FLUSH} state_t;

  // Header keep is informational only; the byte count is authoritative.
  logic unused_keep_insert;
  assign unused_keep_insert = ^keep_insert;

  // {low k bytes of r, top N-k bytes of d}, byte-wise, MSB first.
  function automatic logic [DATA_WD-1:0] merge_beat(input logic [DATA_WD-1:0] r,
                                                    input logic [DATA_WD-1:0] d,
                                                    input int k);
    logic [DATA_WD-1:0] o;
    o = '0;
    for (int p = 0; p < N; p++) begin
      if (p < k) o[8*(N-1-p) +: 8] = r[8*(k-1-p) +: 8];
      else       o[8*(N-1-p) +: 8] = d[8*(N-1-p+k) +: 8];
    end
    return o;
  endfunction

  // Top cnt keep bits set (MSB-aligned contiguous).
  function automatic logic [N-1:0] keep_top(input int cnt);
    logic [N-1:0] m;
    m = '0;
    for (int p = 0; p < N; p++) begin
      if (p < cnt) m[N-1-p] = 1'b1;
    end
    return m;
  endfunction

  function automatic int popcount(input logic [N-1:0] v);
    int c;
    c = 0;
    for (int p = 0; p < N; p++) begin
      if (v[p]) c = c + 1;
    end
    return c;
  endfunction

  // Disabled bytes are driven to zero.
  function automatic logic [DATA_WD-1:0] apply_keep(input logic [DATA_WD-1:0] d,
                                                    input logic [N-1:0] keep);
    logic [DATA_WD-1:0] o;
    o = d;
    for (int p = 0; p < N; p++) begin
      if (!keep[p]) o[8*p +: 8] = 8'h00;
    end
    return o;
  endfunction

  state_t               state, state_d;
  logic [DATA_WD-1:0]   res_p0;        // residual: previous word, low k bytes pending
  logic [BYTE_CNT_WD:0] hdr_cnt_p0;    // k for the current packet
  logic [N-1:0]         flush_keep_p0; // keep of the trailing flush beat
  logic [N-1:0]         flush_keep_d;
  logic                 load_en;
  logic                 beat_vld;
  logic [DATA_WD-1:0]   beat_data;
  logic [N-1:0]         beat_keep;
  logic                 beat_last;
  logic                 acc_in;
  logic                 acc_hdr;
  int                   tot;

  // Output register can take a new beat when empty or being drained.
  assign load_en = !valid_out || ready_out;
  assign acc_in  = valid_in && ready_in;
  assign acc_hdr = valid_insert && ready_insert;

  always_comb begin
    state_d      = state;
    ready_in     = 1'b0;
    ready_insert = 1'b0;
    beat_vld     = 1'b0;
    beat_data    = '0;
    beat_keep    = '0;
    beat_last    = 1'b0;
    flush_keep_d = flush_keep_p0;
    tot          = int'(hdr_cnt_p0) + popcount(keep_in);
    case (state)
      IDLE: begin
        ready_insert = 1'b1;
        if (valid_insert) state_d = DATA;
      end
      DATA: begin
        ready_in = load_en;
        if (valid_in && load_en) begin
          beat_vld  = 1'b1;
          beat_data = merge_beat(res_p0, data_in, int'(hdr_cnt_p0));
          beat_keep = '1;
          if (last_in) begin
            if (tot <= N) begin
              beat_keep = keep_top(tot);
              beat_last = 1'b1;
              state_d   = IDLE;
            end else begin
              // Header plus tail spill past one beat: residual needs a flush beat.
              flush_keep_d = keep_top(tot - N);
              state_d      = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (load_en) begin
          beat_vld  = 1'b1;
          beat_data = merge_beat(res_p0, '0, int'(hdr_cnt_p0));
          beat_keep = flush_keep_p0;
          beat_last = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_n) begin
      ready_in     = 1'b0;
      ready_insert = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_d;
  end

  // Stage p0: residual word, header byte count, pending flush keep.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      res_p0        <= '0;
      hdr_cnt_p0    <= '0;
      flush_keep_p0 <= '0;
    end else begin
      if (acc_hdr) begin
        res_p0     <= data_insert;
        hdr_cnt_p0 <= (int'(byte_insert_cnt) > N) ? (BYTE_CNT_WD+1)'(N) : byte_insert_cnt;
      end
      if (acc_in) begin
        res_p0        <= data_in;
        flush_keep_p0 <= flush_keep_d;
      end
    end
  end

  // Stage p1: output register, holds while stalled by the sink.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else if (load_en) begin
      valid_out <= beat_vld;
      data_out  <= apply_keep(beat_data, beat_keep);
      keep_out  <= beat_keep;
      last_out  <= beat_last;
    end
  end

endmodule

// File: tb/tb_axi_stream_insert_header.sv
module tb_axi_stream_insert_header;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in, last_in, ready_in;
  logic [DW-1:0] data_in;
  logic [N-1:0]  keep_in;
  logic          valid_out, last_out, ready_out;
  logic [DW-1:0] data_out;
  logic [N-1:0]  keep_out;
  logic          valid_insert, ready_insert;
  logic [DW-1:0] data_insert;
  logic [N-1:0]  keep_insert;
  logic [CW:0]   byte_insert_cnt;

  always #5 clk = ~clk;

  axi_stream_insert_header #(.DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out),
    .last_out(last_out), .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert),
    .keep_insert(keep_insert), .byte_insert_cnt(byte_insert_cnt),
    .ready_insert(ready_insert)
  );

  typedef struct packed {logic [31:0] data; logic [3:0] keep; logic last;} beat_t;
  typedef struct packed {logic [31:0] data; logic [2:0] cnt;} hdr_t;
  typedef struct packed {
    logic [31:0]      hdr;
    logic [2:0]       k;
    logic [1:0]       nb;
    logic [1:0][31:0] pd;
    logic [1:0][3:0]  pk;
    logic [1:0]       ne;
    logic [2:0][31:0] ed;
    logic [2:0][3:0]  ek;
    logic [2:0]       el;
  } vec_t;

  hdr_t  hq[$];
  beat_t pq[$];
  beat_t eq[$];
  beat_t pkt[$];
  vec_t  vt[7];
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic vdef(input int i, input logic [31:0] hdr, input int k, input int nb,
                      input logic [31:0] p0, input logic [3:0] k0,
                      input logic [31:0] p1, input logic [3:0] k1, input int ne,
                      input logic [31:0] e0, input logic [3:0] ek0, input logic el0,
                      input logic [31:0] e1, input logic [3:0] ek1, input logic el1,
                      input logic [31:0] e2, input logic [3:0] ek2, input logic el2);
    vt[i].hdr = hdr; vt[i].k = 3'(k); vt[i].nb = 2'(nb);
    vt[i].pd[0] = p0; vt[i].pk[0] = k0; vt[i].pd[1] = p1; vt[i].pk[1] = k1;
    vt[i].ne = 2'(ne);
    vt[i].ed[0] = e0; vt[i].ek[0] = ek0; vt[i].el[0] = el0;
    vt[i].ed[1] = e1; vt[i].ek[1] = ek1; vt[i].el[1] = el1;
    vt[i].ed[2] = e2; vt[i].ek[2] = ek2; vt[i].el[2] = el2;
  endtask

  function automatic int ones(input logic [3:0] v);
    int c;
    c = 0;
    for (int p = 0; p < 4; p++) if (v[p]) c++;
    return c;
  endfunction

  // Reference: lay out header bytes then payload bytes as a flat byte stream,
  // then cut it into N-byte output beats.
  task automatic model_packet(input logic [31:0] hdr, input int k);
    logic [7:0] bq[$];
    beat_t      o;
    hdr_t       h;
    int         n;
    int         c;
    h.data = hdr;
    h.cnt  = 3'(k);
    hq.push_back(h);
    for (int i = k - 1; i >= 0; i--) bq.push_back(hdr[8*i +: 8]);
    foreach (pkt[b]) begin
      pq.push_back(pkt[b]);
      n = pkt[b].last ? ones(pkt[b].keep) : N;
      for (int p = 0; p < n; p++) bq.push_back(pkt[b].data[8*(N-1-p) +: 8]);
    end
    while (bq.size() > 0) begin
      o = '0;
      c = 0;
      while (c < N && bq.size() > 0) begin
        o.data[8*(N-1-c) +: 8] = bq.pop_front();
        o.keep[N-1-c] = 1'b1;
        c++;
      end
      o.last = (bq.size() == 0);
      eq.push_back(o);
    end
  endtask

  // Drive queued headers/payload, check every output beat against eq.
  task automatic run_queues(input string tag, input int rdy_pct, input int vld_pct,
                            input int max_cycles);
    int    cyc;
    bit    hacc, pacc;
    beat_t e;
    cyc = 0;
    while (eq.size() > 0 && cyc < max_cycles) begin
      if (!valid_insert && hq.size() > 0 && $urandom_range(99) < vld_pct) begin
        valid_insert    = 1'b1;
        data_insert     = hq[0].data;
        byte_insert_cnt = hq[0].cnt;
        keep_insert     = 4'((5'd1 << hq[0].cnt) - 5'd1);
      end
      if (!valid_in && pq.size() > 0 && $urandom_range(99) < vld_pct) begin
        valid_in = 1'b1;
        data_in  = pq[0].data;
        keep_in  = pq[0].keep;
        last_in  = pq[0].last;
      end
      ready_out = ($urandom_range(99) < rdy_pct);
      #1;
      hacc = valid_insert && ready_insert;
      pacc = valid_in && ready_in;
      if (valid_out && ready_out) begin
        e = eq.pop_front();
        chk($sformatf("%s_data", tag), data_out, e.data);
        chk($sformatf("%s_keep", tag), 32'(keep_out), 32'(e.keep));
        chk($sformatf("%s_last", tag), 32'(last_out), 32'(e.last));
      end
      @(negedge clk);
      if (hacc) begin void'(hq.pop_front()); valid_insert = 1'b0; end
      if (pacc) begin void'(pq.pop_front()); valid_in = 1'b0; end
      cyc++;
    end
    if (eq.size() > 0) begin
      failures++;
      checks++;
      $display("FAIL %s_timeout actual=%0d_beats_left required=0", tag, eq.size());
    end
    hq.delete(); pq.delete(); eq.delete();
    valid_in = 1'b0; valid_insert = 1'b0; ready_out = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_vec(input int i);
    hdr_t  h;
    beat_t b;
    h.data = vt[i].hdr;
    h.cnt  = vt[i].k;
    hq.push_back(h);
    for (int j = 0; j < int'(vt[i].nb); j++) begin
      b.data = vt[i].pd[j];
      b.keep = vt[i].pk[j];
      b.last = (j == int'(vt[i].nb) - 1);
      pq.push_back(b);
    end
    for (int j = 0; j < int'(vt[i].ne); j++) begin
      b.data = vt[i].ed[j];
      b.keep = vt[i].ek[j];
      b.last = vt[i].el[j];
      eq.push_back(b);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          k, nb, n;
    beat_t       b;

    //    i hdr           k nb p0            k0     p1            k1    ne  expected beats
    vdef(0, 32'hAABBCCDD, 2, 2, 32'h11223344, 4'hF, 32'h55667788, 4'hC, 2,
         32'hCCDD1122, 4'hF, 1'b0, 32'h33445566, 4'hF, 1'b1, 32'h0, 4'h0, 1'b0);
    vdef(1, 32'h00A1B2C3, 3, 1, 32'h11223344, 4'hE, 32'h0, 4'h0, 2,
         32'hA1B2C311, 4'hF, 1'b0, 32'h22330000, 4'hC, 1'b1, 32'h0, 4'h0, 1'b0);
    vdef(2, 32'hDEADBEEF, 4, 1, 32'h12345678, 4'h8, 32'h0, 4'h0, 2,
         32'hDEADBEEF, 4'hF, 1'b0, 32'h12000000, 4'h8, 1'b1, 32'h0, 4'h0, 1'b0);
    vdef(3, 32'h01020304, 0, 2, 32'hCAFEBABE, 4'hF, 32'h0BADF00D, 4'hE, 2,
         32'hCAFEBABE, 4'hF, 1'b0, 32'h0BADF000, 4'hE, 1'b1, 32'h0, 4'h0, 1'b0);
    vdef(4, 32'h000000EE, 1, 1, 32'h11223344, 4'hF, 32'h0, 4'h0, 2,
         32'hEE112233, 4'hF, 1'b0, 32'h44000000, 4'h8, 1'b1, 32'h0, 4'h0, 1'b0);
    vdef(5, 32'h01234567, 4, 2, 32'h89ABCDEF, 4'hF, 32'h13579BDF, 4'hC, 3,
         32'h01234567, 4'hF, 1'b0, 32'h89ABCDEF, 4'hF, 1'b0, 32'h13570000, 4'hC, 1'b1);
    vdef(6, 32'h000000AB, 1, 1, 32'h11223344, 4'hE, 32'h0, 4'h0, 1,
         32'hAB112233, 4'hF, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0);

    rst_n = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    ready_out = 1'b0; valid_insert = 1'b0; data_insert = '0; keep_insert = '0;
    byte_insert_cnt = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_keep_out", 32'(keep_out), 32'd0);
    chk("rst_last_out", 32'(last_out), 32'd0);
    chk("rst_ready_in", 32'(ready_in), 32'd0);
    chk("rst_ready_insert", 32'(ready_insert), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("idle_ready_insert", 32'(ready_insert), 32'd1);
    chk("idle_ready_in", 32'(ready_in), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      load_vec(i);
      run_queues($sformatf("vec%0d", i), 100, 100, 100);
    end

    // Payload before header stalls; header refused in DATA; output stall holds.
    valid_in = 1'b1; data_in = 32'h11223344; keep_in = 4'hF; last_in = 1'b0;
    ready_out = 1'b1;
    repeat (3) begin
      #1 chk("pre_hdr_ready_in", 32'(ready_in), 32'd0);
      @(negedge clk);
    end
    valid_insert = 1'b1; data_insert = 32'hAABBCCDD; byte_insert_cnt = 3'd2; keep_insert = 4'h3;
    #1 chk("hdr_ready_insert", 32'(ready_insert), 32'd1);
    @(negedge clk);
    data_insert = 32'h99999999; byte_insert_cnt = 3'd1; keep_insert = 4'h1;
    ready_out = 1'b0;
    #1;
    chk("data_ready_insert", 32'(ready_insert), 32'd0);
    chk("data_ready_in", 32'(ready_in), 32'd1);
    @(negedge clk);
    data_in = 32'h55667788; keep_in = 4'hC; last_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_valid_out", 32'(valid_out), 32'd1);
      chk("stall_data_out", data_out, 32'hCCDD1122);
      chk("stall_keep_out", 32'(keep_out), 32'hF);
      chk("stall_last_out", 32'(last_out), 32'd0);
      chk("stall_ready_in", 32'(ready_in), 32'd0);
      chk("stall_ready_insert", 32'(ready_insert), 32'd0);
      @(negedge clk);
    end
    ready_out = 1'b1;
    #1 chk("resume_ready_in", 32'(ready_in), 32'd1);
    @(negedge clk);
    valid_in = 1'b0; valid_insert = 1'b0;
    #1;
    chk("resume_valid_out", 32'(valid_out), 32'd1);
    chk("resume_data_out", data_out, 32'h33445566);
    chk("resume_keep_out", 32'(keep_out), 32'hF);
    chk("resume_last_out", 32'(last_out), 32'd1);
    @(negedge clk);
    #1;
    chk("drained_valid_out", 32'(valid_out), 32'd0);
    chk("drained_ready_insert", 32'(ready_insert), 32'd1);
    @(negedge clk);

    // Reset in the middle of a packet.
    valid_insert = 1'b1; data_insert = 32'hAABBCCDD; byte_insert_cnt = 3'd2; keep_insert = 4'h3;
    ready_out = 1'b0;
    @(negedge clk);
    valid_insert = 1'b0;
    valid_in = 1'b1; data_in = 32'h11223344; keep_in = 4'hF; last_in = 1'b0;
    @(negedge clk);
    chk("prerst_valid_out", 32'(valid_out), 32'd1);
    data_in = 32'h55667788; keep_in = 4'hC; last_in = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_in", 32'(ready_in), 32'd0);
    chk("midrst_ready_insert", 32'(ready_insert), 32'd0);
    @(negedge clk);
    chk("midrst_valid_out", 32'(valid_out), 32'd0);
    chk("midrst_keep_out", 32'(keep_out), 32'd0);
    rst_n = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    #1;
    chk("postrst_ready_insert", 32'(ready_insert), 32'd1);
    chk("postrst_ready_in", 32'(ready_in), 32'd0);
    @(negedge clk);
    load_vec(0);
    run_queues("postrst_vec0", 100, 100, 100);

    // Randomized packets against the byte-stream model.
    for (int pass = 0; pass < 2; pass++) begin
      for (int p = 0; p < 40; p++) begin
        pkt.delete();
        k  = $urandom_range(N);
        nb = $urandom_range(1, 4);
        for (int j = 0; j < nb; j++) begin
          d = $urandom;
          b.data = d;
          b.last = (j == nb - 1);
          if (b.last) begin
            n = $urandom_range(1, N);
            b.keep = 4'(8'hF0 >> n);
          end else begin
            b.keep = 4'hF;
          end
          pkt.push_back(b);
        end
        model_packet($urandom, k);
      end
      if (pass == 0) run_queues("rand_full", 100, 100, 2000);
      else           run_queues("rand_bp", 60, 70, 8000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
